// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage to the d_cache CPU-side port.
// Accepts one load/store at a time, drives word-aligned address, lane-shifted
// write data and byte strobes, and returns extended load data or an error
// flag as a one-cycle response pulse. All d_cache-facing outputs are registers.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] data_in,
  output logic [3:0]  data_in_strb,
  input  logic [31:0] data_out,
  input  logic        data_read_valid,
  input  logic        data_write_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [2:0]    op_funct3, op_funct3_next;
  logic          op_wen, op_wen_next;
  logic [1:0]    op_off, op_off_next;
  logic [CW-1:0] count, count_next;
  logic [31:0]   pend_rdata, pend_rdata_next;
  logic          pend_mis, pend_mis_next;
  logic          pend_fault, pend_fault_next;
  logic [31:0]   addr_next, data_in_next, resp_rdata_next;
  logic [3:0]    strb_next;
  logic          ren_next, wen_next;
  logic          resp_valid_next, resp_mis_next, resp_fault_next;
  logic          done;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic is_bad(input logic wen, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = wen;
      3'b101:  bad = wen | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Shift the read word down to the addressed lane and sign/zero-extend.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign req_ready = (state == IDLE) && !reset;
  assign done      = op_wen ? data_write_ready : data_read_valid;

  // Next-state and next-register values; everything holds unless a state changes it.
  always_comb begin
    state_next      = state;
    op_funct3_next  = op_funct3;
    op_wen_next     = op_wen;
    op_off_next     = op_off;
    count_next      = count;
    pend_rdata_next = pend_rdata;
    pend_mis_next   = pend_mis;
    pend_fault_next = pend_fault;
    addr_next       = addr;
    data_in_next    = data_in;
    strb_next       = data_in_strb;
    ren_next        = mem_ren;
    wen_next        = mem_wen;
    resp_valid_next = 1'b0;
    resp_rdata_next = 32'h0000_0000;
    resp_mis_next   = 1'b0;
    resp_fault_next = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_funct3_next  = req_funct3;
          op_wen_next     = req_wen;
          op_off_next     = req_addr[1:0];
          addr_next       = {req_addr[31:2], 2'b00};
          pend_rdata_next = 32'h0000_0000;
          pend_fault_next = 1'b0;
          if (is_bad(req_wen, req_funct3, req_addr[1:0])) begin
            pend_mis_next = 1'b1;
            state_next    = RESP;
          end else begin
            pend_mis_next = 1'b0;
            ren_next      = !req_wen;
            wen_next      = req_wen;
            state_next    = ISSUE;
            if (req_wen) begin
              case (req_funct3[1:0])
                2'b00: begin
                  strb_next    = 4'b0001 << req_addr[1:0];
                  data_in_next = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                  strb_next    = 4'b0011 << req_addr[1:0];
                  data_in_next = {2{req_wdata[15:0]}};
                end
                default: begin
                  strb_next    = 4'b1111;
                  data_in_next = req_wdata;
                end
              endcase
            end else begin
              strb_next    = 4'b0000;
              data_in_next = 32'h0000_0000;
            end
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        // The completion inputs may still show a stale level here, so they are not looked at.
        count_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (done) begin
          ren_next        = 1'b0;
          wen_next        = 1'b0;
          pend_rdata_next = op_wen ? 32'h0000_0000 : extend(op_funct3, op_off, data_out);
          state_next      = RESP;
        end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
          ren_next        = 1'b0;
          wen_next        = 1'b0;
          pend_rdata_next = 32'h0000_0000;
          pend_fault_next = 1'b1;
          state_next      = RESP;
        end else begin
          count_next = count + CW'(1);
        end
      end
      RESP: begin
        resp_valid_next = 1'b1;
        resp_rdata_next = pend_rdata;
        resp_mis_next   = pend_mis;
        resp_fault_next = pend_fault;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
        ren_next   = 1'b0;
        wen_next   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      op_funct3       <= 3'b000;
      op_wen          <= 1'b0;
      op_off          <= 2'b00;
      count           <= '0;
      pend_rdata      <= 32'h0000_0000;
      pend_mis        <= 1'b0;
      pend_fault      <= 1'b0;
      addr            <= 32'h0000_0000;
      data_in         <= 32'h0000_0000;
      data_in_strb    <= 4'b0000;
      mem_ren         <= 1'b0;
      mem_wen         <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0000_0000;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else begin
      state           <= state_next;
      op_funct3       <= op_funct3_next;
      op_wen          <= op_wen_next;
      op_off          <= op_off_next;
      count           <= count_next;
      pend_rdata      <= pend_rdata_next;
      pend_mis        <= pend_mis_next;
      pend_fault      <= pend_fault_next;
      addr            <= addr_next;
      data_in         <= data_in_next;
      data_in_strb    <= strb_next;
      mem_ren         <= ren_next;
      mem_wen         <= wen_next;
      resp_valid      <= resp_valid_next;
      resp_rdata      <= resp_rdata_next;
      resp_misaligned <= resp_mis_next;
      resp_fault      <= resp_fault_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized loads/stores
// against a behavioural model of the access rules and a responsive d_cache.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata, addr, data_in, data_out;
  logic        mem_ren, mem_wen, data_read_valid, data_write_ready;
  logic [3:0]  data_in_strb;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int TMO = 8;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .addr(addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .data_in(data_in), .data_in_strb(data_in_strb),
    .data_out(data_out), .data_read_valid(data_read_valid),
    .data_write_ready(data_write_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: is the request rejected without a memory access?
  function automatic bit model_bad(input bit wen, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << (int'(f3) % 4);
    return !legal || ((a % size) != 0);
  endfunction

  // Reference: extended load result.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] s;
    int b;
    s = w >> (8 * off);
    case (f3)
      3'd0: begin b = int'(s & 32'hFF);   if (b >= 128)   b -= 256;   return 32'(b); end
      3'd1: begin b = int'(s & 32'hFFFF); if (b >= 32768) b -= 65536; return 32'(b); end
      3'd2: return w;
      3'd4: return s & 32'hFF;
      3'd5: return s & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  // One transaction: d = WAIT cycles before completion (-1 = never), stale = completion level during ISSUE.
  task automatic run_op(input bit wen, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int d, input bit stale);
    bit bad, tmo, seen, mem_seen, comp;
    int size, off, resp_k, drop_k, exp_k, n;
    logic [31:0] exp_strb, exp_din, exp_rd;
    bad  = model_bad(wen, f3, a);
    tmo  = !bad && (d < 0 || d > TMO - 1);
    size = 1 << (int'(f3) % 4);
    off  = int'(a % 4);
    exp_strb = wen ? (((32'd1 << size) - 32'd1) << off) : 32'h0;
    exp_din  = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    exp_rd   = (bad || tmo || wen) ? 32'h0 : model_load(f3, off, word);
    exp_k    = bad ? 1 : (tmo ? TMO + 2 : d + 3);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = a; req_wdata = wd;
    data_out = word; data_read_valid = 1'b0; data_write_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    seen = 0; mem_seen = 0; resp_k = -1; drop_k = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 0) begin
        check("busy_ready", req_ready, 1'b0);
        if (!bad) begin
          check("addr", addr, {a[31:2], 2'b00});
          check("strb", data_in_strb, exp_strb);
          check("mem_ren", mem_ren, !wen);
          check("mem_wen", mem_wen, wen);
          if (wen) check("data_in", data_in, exp_din);
        end
      end
      if (mem_ren || mem_wen) mem_seen = 1;
      if (!bad && k > 0 && drop_k < 0 && !(mem_ren || mem_wen)) drop_k = k;
      if (seen) begin check("resp_one_cycle", resp_valid, 1'b0); break; end
      if (resp_valid) begin
        seen = 1; resp_k = k;
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_misaligned", resp_misaligned, bad);
        check("resp_fault", resp_fault, tmo);
      end
      comp = (k == 0) ? stale : (d >= 0 && (k - 1) >= d && (mem_ren || mem_wen));
      data_read_valid  = !wen && comp;
      data_write_ready = wen && comp;
    end
    data_read_valid = 1'b0; data_write_ready = 1'b0;
    check("resp_seen", seen, 1'b1);
    check("resp_latency", resp_k, exp_k);
    if (bad) check("no_mem_access", mem_seen, 1'b0);
    else     check("mem_drop", drop_k, exp_k - 1);
  endtask

  initial begin
    bit w;
    logic [2:0] f;
    int d;
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; data_out = 32'h0;
    data_read_valid = 1'b0; data_write_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_mem", {mem_ren, mem_wen}, 2'b00);
    check("rst_resp", {resp_valid, resp_misaligned, resp_fault}, 3'b000);
    check("rst_addr", addr, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_strb", data_in_strb, 4'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", req_ready, 1'b1);

    run_op(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1, 1'b0); // LB
    run_op(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 1'b0); // LHU
    run_op(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56A5, 32'h0, 2, 1'b0); // SB
    run_op(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, 0, 1'b0);         // LW misaligned
    run_op(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b1); // stale in ISSUE
    run_op(1'b1, 3'd1, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 3, 1'b1); // SH stale
    run_op(1'b0, 3'd1, 32'h8000_0000, 32'h0, 32'h1234_8765, -1, 1'b0); // timeout
    run_op(1'b0, 3'd4, 32'h8000_0001, 32'h0, 32'h0000_F000, TMO - 1, 1'b0); // completion on timeout edge
    run_op(1'b1, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 1'b0);          // illegal store
    run_op(1'b0, 3'd6, 32'h8000_0000, 32'h0, 32'h0, 0, 1'b0);          // illegal load

    // Reset while waiting: no response pulse afterwards.
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_ren", mem_ren, 1'b1);
    reset = 1'b1;
    check("reset_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    check("reset_ren", mem_ren, 1'b0);
    reset = 1'b0;
    d = 0;
    repeat (6) begin @(posedge clk); #1; if (resp_valid) d++; end
    check("reset_no_resp", d, 0);
    check("reset_idle", req_ready, 1'b1);

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_op(w, f, 32'h8000_0000 + $urandom_range(0, 255), $urandom, $urandom, d, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
